regfile_sweep_reader: RTL and testbench

- Read-side master for the N x R register file: sweeps a contiguous, wrapping range of register IDs.
- Drives the register file read-address port and captures each word.
- Delivers words downstream on a valid/ready stream tagged with their register ID.
- Used for register-file dump, debug readout and context save; the write port is untouched.

---
 rtl/regfile_sweep_reader_if.sv | 33 +++
 rtl/regfile_sweep_reader.sv | 112 +++++++++++
 tb/tb_regfile_sweep_reader.sv | 346 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_sweep_reader_if.sv
// Bundle between the register-file sweep reader, its controller, the register
// file read port and the downstream consumer of captured words.
interface regfile_sweep_reader_if #(
    parameter int N = 8,
    parameter int R = 32
);
    localparam int RR = $clog2(R);

    logic          start;
    logic [RR-1:0] base_id;
    logic [RR:0]   count;
    logic [RR-1:0] rf_reg_id_r;
    logic [N-1:0]  rf_data;
    logic [N-1:0]  out_data;
    logic [RR-1:0] out_id;
    logic          out_valid;
    logic          out_ready;
    logic          busy;
    logic          done;

    // Output stream: a beat transfers on a rising edge where out_valid and
    // out_ready are both high; once raised, out_valid stays high with out_data
    // and out_id unchanged until that edge, and out_ready alone does nothing.
    modport master (
        input  start, base_id, count, rf_data, out_ready,
        output rf_reg_id_r, out_data, out_id, out_valid, busy, done
    );

    modport slave (
        output start, base_id, count, rf_data, out_ready,
        input  rf_reg_id_r, out_data, out_id, out_valid, busy, done
    );
endinterface

// File: rtl/regfile_sweep_reader.sv
// Sweeps a wrapping range of register IDs through the register file read port
// and streams each captured word out tagged with its ID.
module regfile_sweep_reader #(
    parameter int N = 8,
    parameter int R = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    regfile_sweep_reader_if.master        sweep_if,
    output logic [1:0]                    dbg_state_o
);
    localparam int RR = $clog2(R);
    localparam int CW = RR + 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(R);
    localparam logic [RR-1:0] ID_LAST = RR'(R - 1);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_HOLD, S_DONE} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [RR-1:0] rf_id_q, rf_id_d;
    logic [N-1:0]  out_data_q, out_data_d;
    logic [RR-1:0] out_id_q, out_id_d;
    logic          out_valid_q, out_valid_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [RR-1:0] rf_id_next;

    // Explicit wrap compare so non-power-of-two R never addresses past R-1.
    assign rf_id_next = (rf_id_q == ID_LAST) ? '0 : rf_id_q + 1'b1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            rf_id_q     <= '0;
            out_data_q  <= '0;
            out_id_q    <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rf_id_q     <= rf_id_d;
            out_data_q  <= out_data_d;
            out_id_q    <= out_id_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rf_id_d     = rf_id_q;
        out_data_d  = out_data_q;
        out_id_d    = out_id_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;

        case (state_q)
            S_IDLE: begin
                if (sweep_if.start) begin
                    if (sweep_if.count != '0) begin
                        cnt_d   = (sweep_if.count > CNT_MAX) ? CNT_MAX : sweep_if.count;
                        rf_id_d = sweep_if.base_id;
                        busy_d  = 1'b1;
                        state_d = S_READ;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_READ: begin
                out_data_d  = sweep_if.rf_data;
                out_id_d    = rf_id_q;
                out_valid_d = 1'b1;
                state_d     = S_HOLD;
            end
            S_HOLD: begin
                if (out_valid_q && sweep_if.out_ready) begin
                    cnt_d       = cnt_q - 1'b1;
                    out_valid_d = 1'b0;
                    if (cnt_q == CW'(1)) begin
                        state_d = S_DONE;
                    end else begin
                        rf_id_d = rf_id_next;
                        state_d = S_READ;
                    end
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // done is registered, so it is high for exactly the cycle spent in DONE.
        done_d = (state_d == S_DONE);
    end

    assign sweep_if.rf_reg_id_r = rf_id_q;
    assign sweep_if.out_data    = out_data_q;
    assign sweep_if.out_id      = out_id_q;
    assign sweep_if.out_valid   = out_valid_q;
    assign sweep_if.busy        = busy_q;
    assign sweep_if.done        = done_q;
    assign dbg_state_o          = state_q;
endmodule

// File: tb/tb_regfile_sweep_reader.sv
// Bench for regfile_sweep_reader: register file model, directed and random
// sweeps, scoreboard of expected (id, data) beats and a final report.
module tb_regfile_sweep_reader;
    localparam int N  = 8;
    localparam int R  = 32;
    localparam int RR = $clog2(R);
    localparam int W  = RR + N;

    typedef struct {
        int   first_valid;
        int   n_hs;
        int   last_hs;
        int   min_gap;
        int   done_pulses;
        int   done_at;
        int   busy_lo;
        int   busy_hi;
        logic busy_after;
        bit   timed_out;
    } obs_t;

    // clock / reset
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    regfile_sweep_reader_if #(.N(N), .R(R)) sw();
    logic [1:0]   dbg_state;
    logic [N-1:0] rf_mem [R];

    assign sw.rf_data = rf_mem[sw.rf_reg_id_r];

    regfile_sweep_reader #(.N(N), .R(R)) dut (
        .clk         (clk),
        .rst         (rst),
        .sweep_if    (sw),
        .dbg_state_o (dbg_state)
    );

    int n_tests = 0;
    int n_fail  = 0;
    logic [W-1:0] exp_q[$];

    // scoreboard: every accepted beat must match the model, stalled beats must hold
    initial begin
        bit           stall;
        logic [W-1:0] stall_beat;
        logic [W-1:0] got;
        logic [W-1:0] exp;
        stall = 1'b0;
        stall_beat = '0;
        forever begin
            @(negedge clk);
            got = {sw.out_id, sw.out_data};
            if (!rst) begin
                stall = 1'b0;
            end else begin
                if (stall) begin
                    n_tests++;
                    if (sw.out_valid !== 1'b1 || got !== stall_beat) begin
                        n_fail++;
                        $display("FAIL hold_stable: got valid=%0b beat=%h, want valid=1 beat=%h",
                                 sw.out_valid, got, stall_beat);
                    end
                end
                if (sw.out_valid === 1'b1 && sw.out_ready === 1'b1) begin
                    n_tests++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL beat_unexpected: got beat=%h, want no beat", got);
                    end else begin
                        exp = exp_q.pop_front();
                        if (got !== exp) begin
                            n_fail++;
                            $display("FAIL beat_data: got id=%0d data=%h, want id=%0d data=%h",
                                     got[W-1:N], got[N-1:0], exp[W-1:N], exp[N-1:0]);
                        end
                    end
                end
                stall = (sw.out_valid === 1'b1) && (sw.out_ready !== 1'b1);
                stall_beat = got;
            end
        end
    end

    // driver tasks
    task automatic rf_write(input int id, input logic [N-1:0] data);
        rf_mem[id] = data;
    endtask

    task automatic model_sweep(input int base, input int cnt);
        int n;
        int id;
        n = (cnt > R) ? R : cnt;
        for (int i = 0; i < n; i++) begin
            id = (base + i) % R;
            exp_q.push_back({RR'(id), rf_mem[id]});
        end
    endtask

    // Returns at the clock edge that samples start; observation counts from there.
    task automatic start_sweep(input int base, input int cnt);
        model_sweep(base, cnt);
        @(posedge clk); #1;
        sw.start   = 1'b1;
        sw.base_id = RR'(base);
        sw.count   = (RR + 1)'(cnt);
        @(posedge clk); #1;
        sw.start   = 1'b0;
    endtask

    // Observation k is the k-th falling edge after the start-sampling edge.
    task automatic collect(input int budget, output obs_t o);
        o.first_valid = -1; o.n_hs = 0; o.last_hs = -1; o.min_gap = 1000;
        o.done_pulses = 0; o.done_at = -1; o.busy_lo = 0; o.busy_hi = 0;
        o.busy_after = 1'bx; o.timed_out = 1'b1;
        for (int k = 1; k <= budget; k++) begin
            @(negedge clk);
            if (sw.out_valid === 1'b1 && o.first_valid < 0) o.first_valid = k;
            if (sw.out_valid === 1'b1 && sw.out_ready === 1'b1) begin
                if (o.last_hs >= 0 && (k - o.last_hs) < o.min_gap) o.min_gap = k - o.last_hs;
                o.last_hs = k;
                o.n_hs++;
            end
            if (sw.busy === 1'b1) o.busy_hi++; else o.busy_lo++;
            if (sw.done === 1'b1) begin
                o.done_pulses++;
                o.done_at = k;
                o.timed_out = 1'b0;
                break;
            end
        end
        if (!o.timed_out) begin
            @(negedge clk);
            o.busy_after = sw.busy;
            if (sw.done === 1'b1) o.done_pulses++;
            @(negedge clk);
            if (sw.done === 1'b1) o.done_pulses++;
        end
    endtask

    // tests
    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_tests++; if (sw.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b, want 0", sw.out_valid); end
        n_tests++; if (sw.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b, want 0", sw.busy); end
        n_tests++; if (sw.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %0b, want 0", sw.done); end
        n_tests++; if ({sw.rf_reg_id_r, sw.out_id, sw.out_data} !== '0) begin
            n_fail++; $display("FAIL reset_regs: got rf_id=%0d out_id=%0d out_data=%h, want 0 0 00",
                               sw.rf_reg_id_r, sw.out_id, sw.out_data);
        end
        n_tests++; if (dbg_state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d, want 0", dbg_state); end
        rst = 1'b1;
    endtask

    task automatic test_full_sweep();
        obs_t o;
        for (int i = 0; i < R; i++) rf_write(i, 8'hA0 + 8'(i));
        sw.out_ready = 1'b1;
        start_sweep(0, 32);
        collect(200, o);
        n_tests++; if (o.timed_out) begin n_fail++; $display("FAIL full_timeout: got no done, want done"); end
        n_tests++; if (o.first_valid != 2) begin n_fail++; $display("FAIL full_first_valid: got %0d, want 2", o.first_valid); end
        n_tests++; if (o.n_hs != 32) begin n_fail++; $display("FAIL full_beats: got %0d, want 32", o.n_hs); end
        n_tests++; if (o.min_gap != 2 || o.last_hs != 64) begin
            n_fail++; $display("FAIL full_spacing: got min_gap=%0d last=%0d, want 2 64", o.min_gap, o.last_hs);
        end
        n_tests++; if (o.done_at != 65 || o.done_pulses != 1) begin
            n_fail++; $display("FAIL full_done: got at=%0d pulses=%0d, want 65 1", o.done_at, o.done_pulses);
        end
        n_tests++; if (o.busy_lo != 0 || o.busy_after !== 1'b0) begin
            n_fail++; $display("FAIL full_busy: got low_cycles=%0d after=%0b, want 0 0", o.busy_lo, o.busy_after);
        end
        n_tests++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL full_left: got %0d beats missing, want 0", exp_q.size()); end
    endtask

    task automatic test_wrap();
        obs_t o;
        start_sweep(30, 4);
        collect(100, o);
        n_tests++; if (o.n_hs != 4 || exp_q.size() != 0) begin
            n_fail++; $display("FAIL wrap_beats: got %0d (left %0d), want 4 (left 0)", o.n_hs, exp_q.size());
        end
        n_tests++; if (o.done_at != o.last_hs + 1 || o.done_pulses != 1) begin
            n_fail++; $display("FAIL wrap_done: got at=%0d pulses=%0d, want %0d 1", o.done_at, o.done_pulses, o.last_hs + 1);
        end
    endtask

    task automatic test_backpressure();
        obs_t o;
        start_sweep(5, 3);
        fork
            collect(100, o);
            begin
                bit found;
                found = 1'b0;
                for (int k = 0; k < 20; k++) begin
                    @(posedge clk); #1;
                    if (sw.out_valid === 1'b1 && sw.out_id === RR'(6)) begin found = 1'b1; break; end
                end
                n_tests++; if (!found) begin n_fail++; $display("FAIL bp_find: got no beat id 6, want beat id 6"); end
                sw.out_ready = 1'b0;
                for (int k = 0; k < 6 && found; k++) begin
                    @(negedge clk);
                    n_tests++;
                    if (sw.out_valid !== 1'b1 || sw.out_id !== RR'(6) || sw.out_data !== 8'hA6) begin
                        n_fail++; $display("FAIL bp_stall: got valid=%0b id=%0d data=%h, want 1 6 a6",
                                           sw.out_valid, sw.out_id, sw.out_data);
                    end
                end
                @(posedge clk); #1;
                sw.out_ready = 1'b1;
            end
        join
        n_tests++; if (o.n_hs != 3 || exp_q.size() != 0) begin
            n_fail++; $display("FAIL bp_beats: got %0d (left %0d), want 3 (left 0)", o.n_hs, exp_q.size());
        end
        n_tests++; if (o.done_at != o.last_hs + 1 || o.done_pulses != 1) begin
            n_fail++; $display("FAIL bp_done: got at=%0d pulses=%0d, want %0d 1", o.done_at, o.done_pulses, o.last_hs + 1);
        end
    endtask

    task automatic test_count_edges();
        obs_t o;
        start_sweep(7, 0);
        collect(20, o);
        n_tests++; if (o.done_at != 1 || o.done_pulses != 1) begin
            n_fail++; $display("FAIL zero_done: got at=%0d pulses=%0d, want 1 1", o.done_at, o.done_pulses);
        end
        n_tests++; if (o.first_valid != -1 || o.busy_hi != 0 || o.busy_after !== 1'b0) begin
            n_fail++; $display("FAIL zero_quiet: got first_valid=%0d busy_cycles=%0d, want -1 0", o.first_valid, o.busy_hi);
        end
        start_sweep(12, 40);
        collect(200, o);
        n_tests++; if (o.n_hs != 32 || exp_q.size() != 0 || o.done_pulses != 1) begin
            n_fail++; $display("FAIL clamp_beats: got %0d (left %0d, done %0d), want 32 (left 0, done 1)",
                               o.n_hs, exp_q.size(), o.done_pulses);
        end
    endtask

    task automatic test_start_ignored();
        obs_t o;
        start_sweep(2, 6);
        fork
            collect(100, o);
            begin
                repeat (4) @(posedge clk);
                #1;
                sw.start = 1'b1; sw.base_id = RR'(10); sw.count = (RR + 1)'(3);
                repeat (4) @(posedge clk);
                #1;
                sw.start = 1'b0;
            end
        join
        n_tests++; if (o.n_hs != 6 || exp_q.size() != 0 || o.done_pulses != 1) begin
            n_fail++; $display("FAIL ignore_start: got %0d beats (left %0d, done %0d), want 6 (left 0, done 1)",
                               o.n_hs, exp_q.size(), o.done_pulses);
        end
    endtask

    task automatic test_reset_mid_sweep();
        obs_t o;
        bit found;
        sw.out_ready = 1'b0;
        start_sweep(0, 8);
        found = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            if (sw.out_valid === 1'b1) begin found = 1'b1; break; end
        end
        n_tests++; if (!found) begin n_fail++; $display("FAIL rst_find: got no valid beat, want valid beat"); end
        #2;
        rst = 1'b0;
        exp_q.delete();
        #1;
        n_tests++; if ({sw.out_valid, sw.busy, sw.done} !== 3'b000) begin
            n_fail++; $display("FAIL rst_async: got valid=%0b busy=%0b done=%0b, want 0 0 0", sw.out_valid, sw.busy, sw.done);
        end
        #3;
        rst = 1'b1;
        sw.out_ready = 1'b1;
        start_sweep(20, 5);
        collect(100, o);
        n_tests++; if (o.first_valid != 2 || o.n_hs != 5 || exp_q.size() != 0 || o.done_pulses != 1) begin
            n_fail++; $display("FAIL rst_restart: got first=%0d beats=%0d left=%0d done=%0d, want 2 5 0 1",
                               o.first_valid, o.n_hs, exp_q.size(), o.done_pulses);
        end
    endtask

    task automatic test_random();
        obs_t o;
        for (int it = 0; it < 8; it++) begin
            int base;
            int cnt;
            int n;
            bit rnd_on;
            for (int i = 0; i < R; i++) rf_write(i, N'($urandom));
            base = $urandom_range(0, R - 1);
            cnt  = $urandom_range(0, 40);
            n    = (cnt > R) ? R : cnt;
            start_sweep(base, cnt);
            rnd_on = 1'b1;
            fork
                begin collect(1000, o); rnd_on = 1'b0; end
                while (rnd_on) begin
                    @(posedge clk); #1;
                    sw.out_ready = 1'($urandom_range(0, 1));
                end
            join
            sw.out_ready = 1'b1;
            n_tests++; if (o.timed_out || o.n_hs != n || exp_q.size() != 0 || o.done_pulses != 1) begin
                n_fail++; $display("FAIL rand_sweep: got beats=%0d left=%0d done=%0d, want %0d 0 1 (base %0d count %0d)",
                                   o.n_hs, exp_q.size(), o.done_pulses, n, base, cnt);
            end
            n_tests++; if (o.first_valid != ((n != 0) ? 2 : -1)) begin
                n_fail++; $display("FAIL rand_first: got %0d, want %0d", o.first_valid, (n != 0) ? 2 : -1);
            end
            exp_q.delete();
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got no finish by 400000, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        sw.start = 1'b0;
        sw.base_id = '0;
        sw.count = '0;
        sw.out_ready = 1'b0;
        for (int i = 0; i < R; i++) rf_mem[i] = '0;
        test_reset();
        test_full_sweep();
        test_wrap();
        test_backpressure();
        test_count_edges();
        test_start_ignored();
        test_reset_mid_sweep();
        test_random();
        // final report
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
